prng_stream: RTL and testbench
==============================

# prng_stream

Parametrised successor to the single-shot `prng` block. It is a xorshift128 pseudo-random generator with a seed-load port, a counted multi-word request, a configurable output word width and an output FIFO with valid/ack backpressure. It sits between the seed source (host or TRNG) and the sampling logic, which consumes random words at its own pace.

## Interface
Parameters:
- `OUT_W`, default 96: output word width. Must be a multiple of 32 and ≥32. K = OUT_W/32 steps are needed per word.
- `DEPTH`, default 4: output FIFO entries. Must be a power of two and ≥2.
- `CNT_W`, default 16: width of the word-count request.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_b` in 1: asynchronous active-low reset.
- `in_seed` in 128: seed value, split as x=[127:96], y=[95:64], z=[63:32], w=[31:0].
- `in_seed_valid` in 1: load `in_seed` (IDLE only).
- `in_ready` in 1: start request for `in_num` words (IDLE only).
- `in_num` in CNT_W: number of words to generate; sampled together with `in_ready`.
- `in_out_ack` in 1: consumer accepts the FIFO head.
- `out_rng` out OUT_W: FIFO head word; 0 when the FIFO is empty.
- `out_valid` out 1: FIFO non-empty.
- `out_busy` out 1: a request is in progress.
- `out_done` out 1: one-cycle pulse when the last requested word has been written into the FIFO.

## Operation
- State update per step: t = x^(x<<11); x←y; y←z; z←w; w←w^(w>>19)^t^(t>>8), all mod 2^32. The step output is the new w.
- Word assembly: step outputs fill the word MSB-first; the first step goes to [OUT_W-1 -: 32].
- Seed load: when `in_seed_valid` is high in IDLE, the state is loaded from `in_seed`. An all-zero seed is replaced by the default seed.
- Default seed (reset value and zero-seed substitute): x=123456789, y=362436069, z=521288629, w=88675123.
- FSM states:
  - IDLE: accepts seed loads and requests.
    - `in_ready`=1 and `in_num`≠0 → GEN, with remaining ← `in_num` and step counter ← 0.
    - `in_ready`=1 and `in_num`=0 → DONE.
    - If `in_seed_valid` and `in_ready` arrive in the same cycle, the seed is loaded first and generation uses the new seed.
  - GEN: one step per cycle.
    - On step K the word is pushed and remaining decrements.
    - If remaining becomes 0 → DONE; otherwise the next word begins.
    - If step K is due but the FIFO is full (occupancy counted before any same-cycle pop), the step is withheld. State, step counter and partial word are all held, and the FSM stays in GEN.
  - DONE: `out_done`=1 for one cycle → IDLE.
- `in_seed_valid` and `in_ready` are ignored outside IDLE.
- The generator state persists across requests; a new request continues the sequence.
- FIFO: show-ahead. A pop occurs when `out_valid`&&`in_out_ack`. `in_out_ack` while empty has no effect. A push and a pop in the same cycle are both performed when not full. Read/write pointers wrap modulo DEPTH.
- `out_busy`=1 in GEN and DONE.

## Timing
- Reset (asynchronous, any time, including mid-request):
  - FSM → IDLE and FIFO emptied.
  - State = default seed, and the partial word is cleared.
  - `out_rng`=0, `out_valid`=0, `out_busy`=0, `out_done`=0.
- Latency: if `in_ready` is sampled at edge E0, steps occur at E1..EK. The word is written at EK, and `out_valid` rises after EK (K=3 for the default).
- Throughput: one word per K cycles while the FIFO is not full.
- `out_done` is high for the cycle after the edge that pushes the last word. For `in_num`=0 it is high for the cycle after E0.
- The next request can be accepted at the edge after `out_done` (IDLE).
- A seed load takes effect at the sampling edge and the new state is visible from the next cycle.

## Test plan
- Reset: assert `rst_b`=0 mid-GEN with 2 words in the FIFO → all outputs 0 immediately. After release, a new request reproduces the default-seed sequence from the start.
- Default seed, `in_num`=1, `OUT_W`=96, `in_out_ack`=1:
  - `out_rng`[95:64]=32'hDCA345EA.
  - The full word matches the C xorshift128 model.
  - `out_valid` rises 3 cycles after the request.
  - `out_done` pulses once.
- Backpressure: `in_num`=10, DEPTH=4, `in_out_ack`=0 → 4 words buffered and generation stalls with `out_busy`=1. Then `in_out_ack`=1 → 10 words in model order, with no duplicates or skips.
- Seed load: `in_seed`=128'h0 → the output equals the default-seed sequence. `in_seed`=128'h1 then `in_num`=2 → the output matches the model for seed x=y=z=0, w=1.
- Ignored inputs: `in_ready`/`in_seed_valid` pulsed during GEN → no effect on count or sequence.
- `in_num`=0: → `out_done` on the next cycle, no FIFO write, and the state is unchanged (the following request continues the prior sequence).

Source files
------------

// File: rtl/prng_stream.sv
// xorshift128 random word stream: seed load, counted multi-word requests,
// OUT_W-bit words assembled MSB-first from 32-bit steps, show-ahead output FIFO.
module prng_stream #(
    parameter int unsigned OUT_W = 96,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [127:0]     in_seed,
    input  logic             in_seed_valid,
    input  logic             in_ready,
    input  logic [CNT_W-1:0] in_num,
    input  logic             in_out_ack,
    output logic [OUT_W-1:0] out_rng,
    output logic             out_valid,
    output logic             out_busy,
    output logic             out_done
);

    localparam int unsigned K      = OUT_W / 32;
    localparam int unsigned STEP_W = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam logic [127:0] DEFAULT_SEED =
        {32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        x_q, y_q, z_q, w_q;
    logic [OUT_W-1:0]   acc_q;
    logic [STEP_W-1:0]  step_q;
    logic [CNT_W-1:0]   remain_q;
    logic [OUT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [OCC_W-1:0]   occ_q;

    logic               load_c, start_c, step_c, push_c, pop_c;
    logic               step_last_c, full_c;
    logic [127:0]       seed_c;
    logic [31:0]        t_c, new_w_c;
    logic [OUT_W-1:0]   word_c, head_c, rng_c;
    logic [OCC_W-1:0]   occ_c;
    logic [PTR_W-1:0]   rd_c;

    // One xorshift128 step and the word it completes
    assign t_c         = x_q ^ (x_q << 11);
    assign new_w_c     = w_q ^ (w_q >> 19) ^ t_c ^ (t_c >> 8);
    assign word_c      = (acc_q << 32) | OUT_W'(new_w_c);
    assign seed_c      = (in_seed == 128'd0) ? DEFAULT_SEED : in_seed;
    assign step_last_c = (step_q == STEP_W'(K - 1));
    assign full_c      = (occ_q == OCC_W'(DEPTH));

    // FIFO bookkeeping; the registered head already reflects this cycle's push/pop
    assign pop_c  = out_valid && in_out_ack;
    assign occ_c  = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
    assign rd_c   = rd_q + PTR_W'(pop_c);
    assign head_c = (push_c && (rd_c == wr_q)) ? word_c : mem[rd_c];
    assign rng_c  = (occ_c != '0) ? head_c : '0;

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        start_c = 1'b0;
        step_c  = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = in_seed_valid;
                if (in_ready) begin
                    start_c = 1'b1;
                    state_d = (in_num != '0) ? GEN : DONE;
                end
            end
            GEN: begin
                // Final step of a word is withheld while the FIFO is full
                if (!(step_last_c && full_c)) begin
                    step_c = 1'b1;
                    if (step_last_c) begin
                        push_c = 1'b1;
                        if (remain_q == CNT_W'(1)) state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            {x_q, y_q, z_q, w_q} <= DEFAULT_SEED;
            acc_q     <= '0;
            step_q    <= '0;
            remain_q  <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            occ_q     <= '0;
            out_rng   <= '0;
            out_valid <= 1'b0;
            out_busy  <= 1'b0;
            out_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_c) begin
                {x_q, y_q, z_q, w_q} <= seed_c;
            end else if (step_c) begin
                x_q <= y_q;
                y_q <= z_q;
                z_q <= w_q;
                w_q <= new_w_c;
            end
            if (start_c) begin
                step_q   <= '0;
                remain_q <= in_num;
            end else if (step_c) begin
                step_q <= step_last_c ? '0 : step_q + STEP_W'(1);
                if (push_c) remain_q <= remain_q - CNT_W'(1);
            end
            if (step_c) acc_q <= word_c;
            if (push_c) wr_q <= wr_q + PTR_W'(1);
            rd_q      <= rd_c;
            occ_q     <= occ_c;
            out_rng   <= rng_c;
            out_valid <= (occ_c != '0);
            out_busy  <= (state_d != IDLE);
            out_done  <= (state_d == DONE);
        end
    end

    // Storage array carries no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_q] <= word_c;
    end

endmodule

// File: tb/tb_prng_stream.sv
// Directed self-checking bench for prng_stream (default parameters).
module tb_prng_stream;

    logic         clk = 1'b0;
    logic         rst_b;
    logic [127:0] in_seed;
    logic         in_seed_valid;
    logic         in_ready;
    logic [15:0]  in_num;
    logic         in_out_ack;
    logic [95:0]  out_rng;
    logic         out_valid;
    logic         out_busy;
    logic         out_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mx, my, mz, mw;

    always #5 clk = ~clk;

    prng_stream #(.OUT_W(96), .DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .in_seed      (in_seed),
        .in_seed_valid(in_seed_valid),
        .in_ready     (in_ready),
        .in_num       (in_num),
        .in_out_ack   (in_out_ack),
        .out_rng      (out_rng),
        .out_valid    (out_valid),
        .out_busy     (out_busy),
        .out_done     (out_done)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 32'd123456789;
        my = 32'd362436069;
        mz = 32'd521288629;
        mw = 32'd88675123;
    endtask

    task automatic model_seed(input logic [127:0] s);
        if (s == 128'd0) model_reset();
        else {mx, my, mz, mw} = s;
    endtask

    task automatic model_word(output logic [95:0] wd);
        logic [31:0] t;
        logic [95:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            t  = mx ^ (mx << 11);
            mx = my;
            my = mz;
            mz = mw;
            mw = mw ^ (mw >> 19) ^ t ^ (t >> 8);
            acc = {acc[63:0], mw};
        end
        wd = acc;
    endtask

    // Returns at the falling edge after the sampling edge
    task automatic request(input logic [15:0] n);
        @(negedge clk);
        in_ready = 1'b1;
        in_num   = n;
        @(negedge clk);
        in_ready = 1'b0;
        in_num   = '0;
    endtask

    // Drains with ack held high; every valid falling-edge sample is a distinct word
    task automatic collect(input int n, input bit poke);
        int got;
        int dones;
        logic [95:0] exp;
        got   = 0;
        dones = 0;
        for (int c = 0; c < 3 * n + 8; c++) begin
            if (poke && c == 1) begin
                in_ready      = 1'b1;
                in_num        = 16'd5;
                in_seed_valid = 1'b1;
                in_seed       = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
            end else if (poke && c == 2) begin
                in_ready      = 1'b0;
                in_num        = '0;
                in_seed_valid = 1'b0;
            end
            if (out_done) dones++;
            if (out_valid) begin
                if (got < n) begin
                    model_word(exp);
                    chk($sformatf("word%0d", got), out_rng, exp);
                end
                got++;
            end
            @(negedge clk);
        end
        chk("word_count", 96'(got), 96'(n));
        chk("done_pulses", 96'(dones), 96'd1);
    endtask

    initial begin
        logic [95:0] exp;
        rst_b         = 1'b0;
        in_seed       = '0;
        in_seed_valid = 1'b0;
        in_ready      = 1'b0;
        in_num        = '0;
        in_out_ack    = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_rng", out_rng, 96'd0);
        chk("rst_valid", 96'(out_valid), 96'd0);
        chk("rst_busy", 96'(out_busy), 96'd0);
        chk("rst_done", 96'(out_done), 96'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // Single word from default seed: latency, first step, done pulse
        in_out_ack = 1'b1;
        request(16'd1);
        chk("lat_busy", 96'(out_busy), 96'd1);
        chk("lat_valid_e0", 96'(out_valid), 96'd0);
        @(negedge clk);
        chk("lat_valid_e1", 96'(out_valid), 96'd0);
        @(negedge clk);
        chk("lat_valid_e2", 96'(out_valid), 96'd0);
        @(negedge clk);
        chk("lat_valid_e3", 96'(out_valid), 96'd1);
        chk("first_step", 96'(out_rng[95:64]), 96'(32'hDCA345EA));
        model_word(exp);
        chk("first_word", out_rng, exp);
        chk("done_e3", 96'(out_done), 96'd1);
        @(negedge clk);
        chk("popped_valid", 96'(out_valid), 96'd0);
        chk("done_e4", 96'(out_done), 96'd0);
        chk("idle_busy", 96'(out_busy), 96'd0);

        // Zero-length request: done next cycle, nothing written, state untouched
        request(16'd0);
        chk("num0_done", 96'(out_done), 96'd1);
        chk("num0_busy", 96'(out_busy), 96'd1);
        chk("num0_valid", 96'(out_valid), 96'd0);
        @(negedge clk);
        chk("num0_done_end", 96'(out_done), 96'd0);
        chk("num0_valid_end", 96'(out_valid), 96'd0);

        // Backpressure: 4 words buffer, generation stalls, then drains in order
        in_out_ack = 1'b0;
        request(16'd10);
        repeat (20) @(negedge clk);
        chk("bp_valid", 96'(out_valid), 96'd1);
        chk("bp_busy", 96'(out_busy), 96'd1);
        chk("bp_done", 96'(out_done), 96'd0);
        in_out_ack = 1'b1;
        collect(10, 1'b0);

        // Request/seed pulses during GEN are ignored
        request(16'd3);
        collect(3, 1'b1);

        // All-zero seed restores the default sequence
        @(negedge clk);
        in_seed_valid = 1'b1;
        in_seed       = '0;
        @(negedge clk);
        in_seed_valid = 1'b0;
        model_seed(128'd0);
        request(16'd1);
        collect(1, 1'b0);

        // Seed load and request in the same cycle use the new seed
        @(negedge clk);
        in_seed_valid = 1'b1;
        in_seed       = 128'h1;
        in_ready      = 1'b1;
        in_num        = 16'd2;
        @(negedge clk);
        in_seed_valid = 1'b0;
        in_ready      = 1'b0;
        in_num        = '0;
        model_seed(128'h1);
        collect(2, 1'b0);

        // Asynchronous reset mid-request with two words buffered
        in_out_ack = 1'b0;
        request(16'd10);
        repeat (6) @(negedge clk);
        chk("pre_rst_valid", 96'(out_valid), 96'd1);
        #2 rst_b = 1'b0;
        #1;
        chk("async_rng", out_rng, 96'd0);
        chk("async_valid", 96'(out_valid), 96'd0);
        chk("async_busy", 96'(out_busy), 96'd0);
        chk("async_done", 96'(out_done), 96'd0);
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        in_out_ack = 1'b1;
        request(16'd1);
        collect(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
